// File: rtl/online_result_collector_pkg.sv
// Shared definitions for the radix-4 online result collectors: FSM states,
// the signed-digit type and the helper that turns a digit into its weight.
package online_pkg;

  // Width of one redundant signed digit as produced by the online operators.
  localparam int DIGIT_BITS = 3;

  // Digit code that a radix-4 operator must never emit (it would mean -4).
  localparam logic [DIGIT_BITS-1:0] DIGIT_ILLEGAL = 3'b100;

  // One signed digit, two's complement, legal range -3..+3.
  typedef logic signed [DIGIT_BITS-1:0] digit_t;

  // Collector control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // Sign-extends a digit to an int; the illegal code contributes nothing so
  // a corrupted digit cannot push the accumulator out of its safe range.
  function automatic int digit_to_int(input digit_t d);
    int v;
    v = int'(d);
    if (d == DIGIT_ILLEGAL) begin
      v = 0;
    end
    return v;
  endfunction

endpackage

// File: rtl/online_result_collector_if.sv
// Handshake/result bundle between an online operator's output stream, the
// result collector and whoever consumes the converted result.
interface online_result_collector_if #(
  parameter int NO_OF_DIGITS = 4,
  parameter int RADIX_BITS   = 3
);

  localparam int DIGITS_W = (2*NO_OF_DIGITS+1)*RADIX_BITS;
  localparam int VALUE_W  = 2*(2*NO_OF_DIGITS+1)+1;

  logic                       start;
  logic                       full_result_sel;
  logic [RADIX_BITS-1:0]      z_in;
  logic [DIGITS_W-1:0]        result_digits;
  logic signed [VALUE_W-1:0]  result_value;
  logic                       result_valid;
  logic                       result_ready;
  logic                       digit_error;
  logic                       start_dropped;
  logic                       busy;

  // Side that issues frames, feeds digits and consumes the result.
  modport master (
    output start,
    output full_result_sel,
    output z_in,
    output result_ready,
    input  result_digits,
    input  result_value,
    input  result_valid,
    input  digit_error,
    input  start_dropped,
    input  busy
  );

  // The collector itself.
  modport slave (
    input  start,
    input  full_result_sel,
    input  z_in,
    input  result_ready,
    output result_digits,
    output result_value,
    output result_valid,
    output digit_error,
    output start_dropped,
    output busy
  );

endinterface

// File: rtl/online_result_collector_otf.sv
// On-the-fly converter: shifts raw signed digits into a right-aligned word
// and accumulates their conventional two's-complement value MSD first.
// Kept free of any framing logic so the divider/sqrt collectors can reuse it.
module otf_converter
  import online_pkg::*;
#(
  parameter int NO_OF_DIGITS = 4,
  parameter int RADIX_BITS   = 3,
  parameter int RADIX        = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         i_clear,
  input  logic                                         i_enable,
  input  logic [RADIX_BITS-1:0]                        i_digit,
  output logic [(2*NO_OF_DIGITS+1)*RADIX_BITS-1:0]     o_digits,
  output logic signed [2*(2*NO_OF_DIGITS+1):0]         o_value,
  output logic                                         o_error
);

  localparam int DIGITS_W   = (2*NO_OF_DIGITS+1)*RADIX_BITS;
  localparam int VALUE_W    = 2*(2*NO_OF_DIGITS+1)+1;
  localparam int RADIX_LOG2 = $clog2(RADIX);

  logic [DIGITS_W-1:0]       r_digits;
  logic signed [VALUE_W-1:0] r_value;
  logic                      r_error;

  logic                      w_illegal;
  logic signed [VALUE_W-1:0] w_digit_ext;

  // Decode the incoming digit: flag the forbidden code and widen its weight.
  always_comb begin
    w_illegal   = (i_digit == DIGIT_ILLEGAL);
    w_digit_ext = VALUE_W'(digit_to_int(digit_t'(i_digit)));
  end

  // Clear wins over capture so a new frame always starts from zero; each
  // capture multiplies the running value by the radix and adds the digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_value  <= '0;
      r_error  <= 1'b0;
    end else if (i_clear) begin
      r_digits <= '0;
      r_value  <= '0;
      r_error  <= 1'b0;
    end else if (i_enable) begin
      r_digits <= {r_digits[DIGITS_W-RADIX_BITS-1:0], i_digit};
      r_value  <= (r_value <<< RADIX_LOG2) + w_digit_ext;
      r_error  <= r_error | w_illegal;
    end
  end

  assign o_digits = r_digits;
  assign o_value  = r_value;
  assign o_error  = r_error;

endmodule

// File: rtl/online_result_collector.sv
// Receives the MSD-first digit stream of a radix-4 online operator, skips its
// online delay, captures K digits and offers digits plus converted value
// through a valid/ready handshake.
module online_result_collector
  import online_pkg::*;
#(
  parameter int NO_OF_DIGITS = 4,
  parameter int RADIX_BITS   = 3,
  parameter int RADIX        = 4,
  parameter int DELTA        = 2
) (
  input  logic                      clk,
  input  logic                      extern_reset_n,
  online_result_collector_if.slave  bus
);

  localparam int K_FULL    = 2*NO_OF_DIGITS+1;
  localparam int K_TRUNC   = NO_OF_DIGITS+1;
  localparam int CNT_W     = $clog2(K_FULL+DELTA+1);
  localparam int SKIP_LAST = (DELTA > 0) ? DELTA-1 : 0;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic               r_full;
  logic               w_full_next;
  logic               r_start_dropped;

  logic               w_accept;
  logic               w_drop;
  logic               w_capture;
  logic [CNT_W-1:0]   w_k_last;

  // Index of the final capture for the digit count latched at start.
  always_comb begin
    w_k_last = r_full ? CNT_W'(K_FULL-1) : CNT_W'(K_TRUNC-1);
  end

  // Next-state logic: frame acceptance, delay skipping, digit counting and
  // the result handshake; a start that cannot be taken is reported as dropped.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_full_next  = r_full;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    w_capture    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
        end
      end

      ST_SKIP: begin
        w_drop = bus.start;
        if (r_count == CNT_W'(SKIP_LAST)) begin
          w_state_next = ST_COLLECT;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + CNT_W'(1);
        end
      end

      ST_COLLECT: begin
        w_drop    = bus.start;
        w_capture = 1'b1;
        if (r_count == w_k_last) begin
          w_state_next = ST_HOLD;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (bus.result_ready) begin
          if (bus.start) begin
            w_accept = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_drop = bus.start;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_accept) begin
      w_full_next  = bus.full_result_sel;
      w_count_next = '0;
      w_state_next = (DELTA == 0) ? ST_COLLECT : ST_SKIP;
    end
  end

  // State, counter, latched result length and the registered drop pulse.
  always_ff @(posedge clk or negedge extern_reset_n) begin
    if (!extern_reset_n) begin
      r_state         <= ST_IDLE;
      r_count         <= '0;
      r_full          <= 1'b1;
      r_start_dropped <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_count         <= w_count_next;
      r_full          <= w_full_next;
      r_start_dropped <= w_drop;
    end
  end

  otf_converter #(
    .NO_OF_DIGITS (NO_OF_DIGITS),
    .RADIX_BITS   (RADIX_BITS),
    .RADIX        (RADIX)
  ) u_otf (
    .clk      (clk),
    .rst_n    (extern_reset_n),
    .i_clear  (w_accept),
    .i_enable (w_capture),
    .i_digit  (bus.z_in),
    .o_digits (bus.result_digits),
    .o_value  (bus.result_value),
    .o_error  (bus.digit_error)
  );

  assign bus.result_valid  = (r_state == ST_HOLD);
  assign bus.busy          = (r_state == ST_SKIP) || (r_state == ST_COLLECT);
  assign bus.start_dropped = r_start_dropped;

endmodule

// File: tb/tb_online_result_collector.sv
// Randomised scoreboard bench for online_result_collector: a driver issues
// frames and queues the expected result, a monitor checks each result as it
// appears and verifies it stays frozen while the consumer stalls.
module tb_online_result_collector;

  localparam int N      = 4;
  localparam int RB     = 3;
  localparam int DELTA  = 2;
  localparam int KFULL  = 2*N+1;
  localparam int DW     = KFULL*RB;
  localparam int VW     = 2*KFULL+1;

  typedef struct {
    logic [DW-1:0] digits;
    longint        value;
    logic          err;
    int            cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic [RB-1:0] fd [KFULL];

  online_result_collector_if #(.NO_OF_DIGITS(N), .RADIX_BITS(RB)) ifc ();

  online_result_collector #(
    .NO_OF_DIGITS (N),
    .RADIX_BITS   (RB),
    .RADIX        (4),
    .DELTA        (DELTA)
  ) dut (
    .clk            (clk),
    .extern_reset_n (rstN),
    .bus            (ifc.slave)
  );

  // Free-running clock and an edge counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sum of digit weights by explicit powers of four.
  function automatic longint refValue(input int k);
    longint acc;
    longint d;
    acc = 0;
    for (int i = 0; i < k; i++) begin
      d = (fd[i] == 3'b100) ? 64'sd0 : longint'($signed(fd[i]));
      acc += d * (longint'(1) <<< (2*(k-1-i)));
    end
    return acc;
  endfunction

  function automatic logic [DW-1:0] refDigits(input int k);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < k; i++) w[(k-1-i)*RB +: RB] = fd[i];
    return w;
  endfunction

  function automatic logic refError(input int k);
    logic e;
    e = 1'b0;
    for (int i = 0; i < k; i++) if (fd[i] == 3'b100) e = 1'b1;
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic fillRandom(input bit allowIllegal);
    for (int i = 0; i < KFULL; i++) begin
      fd[i] = RB'($urandom_range(0, 7));
      if (!allowIllegal && fd[i] == 3'b100) fd[i] = 3'b000;
    end
  endtask

  // Issues one frame starting at the current falling edge; returns in HOLD
  // with ready low after the requested number of stalled cycles.
  task automatic applyStimulus(input bit full, input int hold, input bit pulseDrop);
    int k;
    int e0;
    int drops;
    exp_t e;
    k = full ? KFULL : N+1;
    ifc.start = 1'b1;
    ifc.full_result_sel = full;
    ifc.result_ready = 1'b1;
    ifc.z_in = RB'($urandom_range(0, 7));
    @(posedge clk); @(negedge clk);
    e0 = cyc;
    ifc.start = 1'b0;
    ifc.result_ready = 1'b0;
    ifc.full_result_sel = 1'($urandom_range(0, 1));
    e.digits = refDigits(k);
    e.value  = refValue(k);
    e.err    = refError(k);
    e.cycle  = e0 + DELTA + k;
    sb.push_back(e);
    checkOutput("clearedValue", longint'(ifc.result_value), 0);
    checkOutput("clearedDigits", longint'(ifc.result_digits), 0);
    checkOutput("clearedError", longint'(ifc.digit_error), 0);
    checkOutput("busyAfterStart", longint'(ifc.busy), 1);
    for (int j = 1; j <= DELTA + k; j++) begin
      ifc.z_in  = (j <= DELTA) ? RB'($urandom_range(0, 7)) : fd[j-DELTA-1];
      ifc.start = pulseDrop && (j == DELTA + 2);
      @(posedge clk); @(negedge clk);
      checkOutput("dropInFrame", longint'(ifc.start_dropped), (pulseDrop && j == DELTA + 2) ? 1 : 0);
    end
    ifc.start = 1'b0;
    drops = 0;
    for (int h = 0; h < hold; h++) begin
      ifc.start = pulseDrop && (h == 1);
      ifc.z_in  = RB'($urandom_range(0, 7));
      @(posedge clk); @(negedge clk);
      checkOutput("holdValid", longint'(ifc.result_valid), 1);
      if (ifc.start_dropped) drops++;
    end
    ifc.start = 1'b0;
    if (hold >= 2) checkOutput("dropInHold", drops, pulseDrop ? 1 : 0);
  endtask

  // Lets the consumer take a pending result without starting a new frame.
  task automatic drainResult();
    ifc.result_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ifc.result_ready = 1'b0;
    checkOutput("idleValid", longint'(ifc.result_valid), 0);
    checkOutput("idleBusy", longint'(ifc.busy), 0);
  endtask

  // Starts a frame with an illegal first digit and resets at the 4th capture.
  task automatic applyResetMidFrame();
    fillRandom(1'b0);
    fd[0] = 3'b100;
    ifc.start = 1'b1;
    ifc.full_result_sel = 1'b1;
    @(posedge clk); @(negedge clk);
    ifc.start = 1'b0;
    for (int j = 1; j <= DELTA + 3; j++) begin
      ifc.z_in = (j <= DELTA) ? 3'b000 : fd[j-DELTA-1];
      @(posedge clk); @(negedge clk);
    end
    checkOutput("preResetError", longint'(ifc.digit_error), 1);
    ifc.z_in = fd[3];
    rstN = 1'b0;
    #1;
    checkOutput("rstValue", longint'(ifc.result_value), 0);
    checkOutput("rstDigits", longint'(ifc.result_digits), 0);
    checkOutput("rstError", longint'(ifc.digit_error), 0);
    checkOutput("rstBusy", longint'(ifc.busy), 0);
    checkOutput("rstValid", longint'(ifc.result_valid), 0);
    @(posedge clk); @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: pops the expected result when valid rises and checks that the
  // presented result stays frozen for as long as valid is held.
  logic          prevValid = 1'b0;
  logic [DW-1:0] snapDigits;
  longint        snapValue;
  logic          snapErr;
  always @(negedge clk) begin
    exp_t cur;
    if (ifc.result_valid && !prevValid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpectedResult: got valid with no frame pending, required none");
      end else begin
        cur = sb.pop_front();
        checkOutput("resultDigits", longint'(ifc.result_digits), longint'(cur.digits));
        checkOutput("resultValue", longint'(ifc.result_value), cur.value);
        checkOutput("digitError", longint'(ifc.digit_error), longint'(cur.err));
        checkOutput("validCycle", cyc, cur.cycle);
      end
      snapDigits = ifc.result_digits;
      snapValue  = longint'(ifc.result_value);
      snapErr    = ifc.digit_error;
    end else if (ifc.result_valid) begin
      checkOutput("holdStable",
                  (ifc.result_digits == snapDigits && longint'(ifc.result_value) == snapValue
                   && ifc.digit_error == snapErr) ? 1 : 0, 1);
    end
    prevValid = ifc.result_valid;
  end

  // Watchdog so the run always ends even if the design stalls.
  initial begin
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset state, directed frames, reset abort, random frames.
  initial begin
    ifc.start = 1'b0;
    ifc.full_result_sel = 1'b0;
    ifc.z_in = '0;
    ifc.result_ready = 1'b0;
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetValid", longint'(ifc.result_valid), 0);
    checkOutput("resetBusy", longint'(ifc.busy), 0);
    checkOutput("resetValue", longint'(ifc.result_value), 0);
    checkOutput("resetDigits", longint'(ifc.result_digits), 0);
    checkOutput("resetError", longint'(ifc.digit_error), 0);
    checkOutput("resetDropped", longint'(ifc.start_dropped), 0);
    rstN = 1'b1;
    @(negedge clk);

    foreach (fd[i]) fd[i] = 3'b011;
    applyStimulus(1'b1, 2, 1'b0);
    foreach (fd[i]) fd[i] = 3'b101;
    applyStimulus(1'b1, 0, 1'b0);
    foreach (fd[i]) fd[i] = 3'b000;
    fd[0] = 3'b001; fd[1] = 3'b111; fd[4] = 3'b010; fd[5] = 3'b011;
    applyStimulus(1'b0, 1, 1'b0);
    foreach (fd[i]) fd[i] = 3'b000;
    fd[2] = 3'b100;
    applyStimulus(1'b1, 0, 1'b0);
    fillRandom(1'b0);
    applyStimulus(1'b1, 5, 1'b1);
    fillRandom(1'b1);
    applyStimulus(1'($urandom_range(0, 1)), 1, 1'b0);
    drainResult();

    applyResetMidFrame();
    foreach (fd[i]) fd[i] = 3'b001;
    applyStimulus(1'b1, 0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      fillRandom(1'b1);
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) drainResult();
    end
    drainResult();

    for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk);
    checkOutput("scoreboardEmpty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
